apb_master: RTL and testbench
=============================

# apb_master

Single-outstanding APB (AMBA 3) requester that converts a valid/ready command port into SETUP/ACCESS bus transfers toward APB completers such as the on-chip RAM slave. It sits between a local controller (CPU shim, DMA, or test sequencer) and the APB bus, and returns one response per command. A bounded wait-state timeout guarantees forward progress if a completer never asserts PREADY.

## Interface
- DATAWIDTH, 32, width of PWDATA/PRDATA/cmd_wdata/rsp_rdata
- ADDRWIDTH, 8, width of PADDR/cmd_addr
- TIMEOUT, 16, max consecutive ACCESS cycles with PREADY low before forced error completion; 0 disables timeout
- PCLK  input  1  bus clock; all logic on rising edge
- PRESETn  input  1  reset, asynchronous, active-low
- cmd_valid  input  1  command request
- cmd_ready  output  1  command accepted on edge where cmd_valid && cmd_ready
- cmd_write  input  1  1 = write, 0 = read
- cmd_addr  input  ADDRWIDTH  target address
- cmd_wdata  input  DATAWIDTH  write data (ignored for reads)
- rsp_valid  output  1  one-cycle completion pulse
- rsp_rdata  output  DATAWIDTH  read data; 0 for writes and errors
- rsp_err  output  1  1 = timeout completion (valid with rsp_valid)
- PSEL, PENABLE, PWRITE  output  1 each  APB control
- PADDR  output  ADDRWIDTH  APB address
- PWDATA  output  DATAWIDTH  APB write data
- PRDATA  input  DATAWIDTH  APB read data
- PREADY  input  1  completer ready

## Operation
- States: IDLE, SETUP, ACCESS. Reset -> IDLE.
- IDLE: cmd_ready=1, PSEL=0, PENABLE=0. On cmd_valid: latch cmd_write/addr/wdata into PWRITE/PADDR/PWDATA, go SETUP.
- SETUP: PSEL=1, PENABLE=0, cmd_ready=0; unconditionally go ACCESS next edge.
- ACCESS: PSEL=1, PENABLE=1. On edge with PREADY=1: rsp_valid=1, rsp_err=0, rsp_rdata=PRDATA if read else 0; go IDLE.
- Wait counter: cleared on entry to ACCESS, increments each ACCESS edge with PREADY=0. When TIMEOUT!=0 and counter reaches TIMEOUT with PREADY still 0: rsp_valid=1, rsp_err=1, rsp_rdata=0, go IDLE. PREADY=1 on the same edge the limit is reached wins (normal completion).
- Counter width = clog2(TIMEOUT+1); no wrap possible.
- PADDR/PWRITE/PWDATA stable from SETUP through last ACCESS cycle; hold last value in IDLE.
- cmd_ready is a registered-state decode (1 only in IDLE); no combinational path from PREADY to cmd_ready.
- rsp has no backpressure; consumer must accept the pulse.
- PRDATA ignored except on a completing read edge.
- Reset (any state, any time): all outputs to 0 (cmd_ready=0 while PRESETn low, 1 on first cycle after release), state IDLE, counter 0, in-flight command dropped with no response.

## Timing
- Command accepted at edge N; SETUP visible N..N+1; ACCESS from N+1; with zero wait states completion at edge N+2, rsp_valid high N+2..N+3, cmd_ready high from N+2.
- Minimum spacing between accepted commands: 3 cycles (no SETUP-after-ACCESS shortcut).
- Each wait state adds one cycle; timeout completion at edge N+1+TIMEOUT.
- rsp_valid, rsp_rdata, rsp_err registered; rsp_rdata and rsp_err return to 0 when rsp_valid falls.

## Test plan
- Reset: assert PRESETn=0 mid-ACCESS -> PSEL/PENABLE/rsp_valid drop to 0 asynchronously; no rsp after release; cmd_ready=1 one cycle after release.
- Zero-wait write: cmd addr 0x10, wdata 0xDEADBEEF, PREADY tied 1 -> PSEL 1 for 2 cycles, PENABLE 1 in second, PWDATA=0xDEADBEEF, rsp_valid at N+2, rsp_err=0, rsp_rdata=0.
- Read with 3 wait states: addr 0x10, PREADY low 3 ACCESS cycles then high with PRDATA=0xDEADBEEF -> PADDR stable throughout, rsp_rdata=0xDEADBEEF at N+5.
- Timeout: TIMEOUT=16, PREADY stuck 0 -> rsp_valid with rsp_err=1, rsp_rdata=0 at N+17; PSEL/PENABLE 0 next cycle. Repeat with PREADY rising exactly on edge N+17 -> rsp_err=0.
- Back-to-back: cmd_valid held high with 4 commands (W 0x01, R 0x01, W 0xFF, R 0xFF) against RAM model -> accepts spaced 3 cycles, read data matches written data, exactly 4 rsp pulses.
- TIMEOUT=0: PREADY low 100 cycles then high -> no error, single normal completion.

Source files
------------

// File: rtl/apb_master_if.sv
// Command/response port plus APB bus signals for the single-outstanding APB requester.
// master is the requester view, slave is the completer/command-source view.
interface apb_master_if #(
  parameter int DATAWIDTH = 32,
  parameter int ADDRWIDTH = 8
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic                 cmd_write;
  logic [ADDRWIDTH-1:0] cmd_addr;
  logic [DATAWIDTH-1:0] cmd_wdata;
  logic                 rsp_valid;
  logic [DATAWIDTH-1:0] rsp_rdata;
  logic                 rsp_err;
  logic                 PSEL;
  logic                 PENABLE;
  logic                 PWRITE;
  logic [ADDRWIDTH-1:0] PADDR;
  logic [DATAWIDTH-1:0] PWDATA;
  logic [DATAWIDTH-1:0] PRDATA;
  logic                 PREADY;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );
endinterface

// File: rtl/apb_master.sv
// Single-outstanding APB requester: valid/ready command in, one registered response out.
// A nonzero TIMEOUT bounds the ACCESS wait states and forces an error completion.
//
// state  | meaning
// IDLE   | bus idle, command port ready
// SETUP  | PSEL high, address/control phase
// ACCESS | PSEL and PENABLE high, waiting on PREADY or timeout
module apb_master #(
  parameter int DATAWIDTH = 32,
  parameter int ADDRWIDTH = 8,
  parameter int TIMEOUT   = 16
) (
  input logic          PCLK,
  input logic          PRESETn,
  apb_master_if.master bus
);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic [CW-1:0]        wait_cnt, wait_cnt_nxt;
  logic                 accept;
  logic                 done_ok;
  logic                 done_tmo;
  logic [DATAWIDTH-1:0] rdata_nxt;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    accept       = 1'b0;
    done_ok      = 1'b0;
    done_tmo     = 1'b0;
    rdata_nxt    = '0;
    unique case (state)
      IDLE: begin
        if (bus.cmd_valid && bus.cmd_ready) begin
          accept    = 1'b1;
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        wait_cnt_nxt = '0;
        state_nxt    = ACCESS;
      end
      ACCESS: begin
        // PREADY on the limit edge still counts as a normal completion
        if (bus.PREADY) begin
          done_ok   = 1'b1;
          state_nxt = IDLE;
          if (!bus.PWRITE) rdata_nxt = bus.PRDATA;
        end else if (TIMEOUT != 0 && int'(wait_cnt) + 1 == TIMEOUT) begin
          done_tmo  = 1'b1;
          state_nxt = IDLE;
        end else if (TIMEOUT != 0) begin
          wait_cnt_nxt = wait_cnt + CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.PSEL    = (state != IDLE);
  assign bus.PENABLE = (state == ACCESS);

  // cmd_ready comes from a flop so it stays low during reset and has no PREADY path
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      bus.cmd_ready <= 1'b0;
      bus.PWRITE    <= 1'b0;
      bus.PADDR     <= '0;
      bus.PWDATA    <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_err   <= 1'b0;
      bus.rsp_rdata <= '0;
    end else begin
      bus.cmd_ready <= (state_nxt == IDLE);
      if (accept) begin
        bus.PWRITE <= bus.cmd_write;
        bus.PADDR  <= bus.cmd_addr[ADDRWIDTH-1:0];
        bus.PWDATA <= bus.cmd_wdata;
      end
      bus.rsp_valid <= done_ok | done_tmo;
      bus.rsp_err   <= done_tmo;
      bus.rsp_rdata <= rdata_nxt;
    end
  end
endmodule

// File: tb/tb_apb_master.sv
// Randomized bench for apb_master: a timeline model predicts every bus/response cycle from
// the accept edge and the completer wait count, plus directed latency and reset checks.
module tb_apb_master;
  localparam int DW  = 32;
  localparam int AW  = 8;
  localparam int TMO = 16;

  logic PCLK    = 1'b0;
  logic PRESETn = 1'b0;
  always #5 PCLK = ~PCLK;

  apb_master_if #(.DATAWIDTH(DW), .ADDRWIDTH(AW)) bus ();
  apb_master_if #(.DATAWIDTH(DW), .ADDRWIDTH(AW)) bus0 ();

  apb_master #(.DATAWIDTH(DW), .ADDRWIDTH(AW), .TIMEOUT(TMO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .bus(bus)
  );
  apb_master #(.DATAWIDTH(DW), .ADDRWIDTH(AW), .TIMEOUT(0)) dut0 (
    .PCLK(PCLK), .PRESETn(PRESETn), .bus(bus0)
  );

  int tests = 0;
  int fails = 0;

  // model: the last accepted command fully determines the bus timeline
  int          cyc, next_ok, n_acc, drv_w;
  bit          have, a_err, a_write, chk_en;
  int          a_n, a_e, a_w;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata, a_rdata;
  logic [DW-1:0] mem [256];
  logic [DW-1:0] ref_mem [256];
  int          acc_idx;
  int          rsp_seen;
  logic [DW-1:0] rd_log [1024];

  function automatic logic [DW-1:0] init_val(int i);
    return (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      cyc = 0; next_ok = 2; have = 0;
      a_n = 0; a_e = 0; a_err = 0; a_write = 0; a_addr = '0; a_wdata = '0; a_rdata = '0;
    end else begin
      cyc++;
      if (have && cyc == a_e && a_write && !a_err) ref_mem[a_addr] = a_wdata;
      if (bus.cmd_valid && cyc >= next_ok) begin
        a_n = cyc; a_w = drv_w; a_write = bus.cmd_write;
        a_addr = bus.cmd_addr; a_wdata = bus.cmd_wdata;
        if (drv_w >= TMO) begin
          a_e = cyc + 1 + TMO; a_err = 1; a_rdata = '0;
        end else begin
          a_e = cyc + 2 + drv_w; a_err = 0;
          a_rdata = a_write ? '0 : ref_mem[a_addr];
        end
        next_ok = a_e + 1;
        have = 1;
        n_acc++;
      end
    end
  end

  // completer: PREADY low for a_w ACCESS cycles, garbage PRDATA whenever it is not sampled
  always @(negedge PCLK) begin
    if (bus.PSEL && bus.PENABLE) begin
      bus.PREADY = (acc_idx >= a_w);
      acc_idx++;
      if (bus.PREADY && bus.PWRITE) mem[bus.PADDR] = bus.PWDATA;
      bus.PRDATA = (bus.PREADY && !bus.PWRITE) ? mem[bus.PADDR] : DW'($urandom);
    end else begin
      acc_idx = 0;
      bus.PREADY = 1'($urandom_range(0, 1));
      bus.PRDATA = DW'($urandom);
    end
  end

  always @(negedge PCLK) begin
    if (PRESETn && bus.rsp_valid) begin
      rd_log[rsp_seen % 1024] = bus.rsp_rdata;
      rsp_seen++;
    end
  end

  always @(negedge PCLK) begin
    if (chk_en && PRESETn) begin
      int k;
      bit busy, acc, rv;
      k    = cyc;
      busy = have && k >= a_n && k < a_e;
      acc  = have && k >= a_n + 1 && k < a_e;
      rv   = have && k == a_e;
      check("cmd_ready", 64'(bus.cmd_ready), 64'(k >= next_ok - 1));
      check("psel", 64'(bus.PSEL), 64'(busy));
      check("penable", 64'(bus.PENABLE), 64'(acc));
      check("paddr", 64'(bus.PADDR), 64'(a_addr));
      check("pwrite", 64'(bus.PWRITE), 64'(a_write));
      check("pwdata", 64'(bus.PWDATA), 64'(a_wdata));
      check("rsp_valid", 64'(bus.rsp_valid), 64'(rv));
      check("rsp_err", 64'(bus.rsp_err), 64'(rv && a_err));
      check("rsp_rdata", 64'(bus.rsp_rdata), 64'(rv ? a_rdata : '0));
    end
  end

  // entered and left at a negedge; hold keeps cmd_valid high for back-to-back streams
  task automatic send(input bit wr, input logic [AW-1:0] ad, input logic [DW-1:0] wd,
                      input int w, input bit hold);
    int start, budget;
    start = n_acc; budget = 0;
    bus.cmd_valid = 1'b1; bus.cmd_write = wr; bus.cmd_addr = ad; bus.cmd_wdata = wd;
    drv_w = w;
    do begin
      @(negedge PCLK);
      budget++;
    end while (n_acc == start && budget < 100);
    check("accept", 64'(n_acc != start), 64'd1);
    if (!hold) bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int at, output logic err, output logic [DW-1:0] rd);
    at = -1; err = 1'b0; rd = '0;
    for (int i = 0; i < 60; i++) begin
      @(negedge PCLK);
      if (bus.rsp_valid) begin
        at = cyc; err = bus.rsp_err; rd = bus.rsp_rdata;
        break;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, at, base, n1, n2, n3, n4, acc0, pulses0, n0, at0;
    logic err, err0;
    logic [DW-1:0] rd, rd0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = init_val(i);
      ref_mem[i] = init_val(i);
    end
    n_acc = 0; drv_w = 0; chk_en = 0; rsp_seen = 0; acc_idx = 0; a_w = 0;
    bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
    bus0.cmd_valid = 0; bus0.cmd_write = 0; bus0.cmd_addr = '0; bus0.cmd_wdata = '0;
    bus0.PREADY = 0; bus0.PRDATA = '0;

    repeat (3) @(negedge PCLK);
    check("rst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    check("rst_psel", 64'(bus.PSEL), 64'd0);
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    #2 PRESETn = 1'b1;
    check("post_rst_ready_early", 64'(bus.cmd_ready), 64'd0);
    chk_en = 1;
    @(negedge PCLK);
    check("post_rst_ready", 64'(bus.cmd_ready), 64'd1);

    // zero-wait write
    send(1'b1, 8'h10, 32'hDEADBEEF, 0, 1'b0);
    n = cyc;
    check("wr_setup_psel", 64'(bus.PSEL), 64'd1);
    check("wr_setup_penable", 64'(bus.PENABLE), 64'd0);
    check("wr_pwdata", 64'(bus.PWDATA), 64'hDEADBEEF);
    check("model_wr_end", 64'(a_e - a_n), 64'd2);
    wait_rsp(at, err, rd);
    check("wr_latency", 64'(at - n), 64'd2);
    check("wr_err", 64'(err), 64'd0);
    check("wr_rdata", 64'(rd), 64'd0);

    // read with 3 wait states
    send(1'b0, 8'h10, 32'h0, 3, 1'b0);
    n = cyc;
    wait_rsp(at, err, rd);
    check("rd3_latency", 64'(at - n), 64'd5);
    check("rd3_rdata", 64'(rd), 64'hDEADBEEF);
    check("rd3_err", 64'(err), 64'd0);

    // PREADY stuck low: timeout
    send(1'b0, 8'h10, 32'h0, 16, 1'b0);
    n = cyc;
    check("model_tmo_end", 64'(a_e - a_n), 64'd17);
    wait_rsp(at, err, rd);
    check("tmo_latency", 64'(at - n), 64'd17);
    check("tmo_err", 64'(err), 64'd1);
    check("tmo_rdata", 64'(rd), 64'd0);
    check("tmo_psel_after", 64'(bus.PSEL), 64'd0);
    check("tmo_penable_after", 64'(bus.PENABLE), 64'd0);

    // PREADY rises on the limit edge: normal completion wins
    send(1'b0, 8'h10, 32'h0, 15, 1'b0);
    n = cyc;
    wait_rsp(at, err, rd);
    check("edge_latency", 64'(at - n), 64'd17);
    check("edge_err", 64'(err), 64'd0);
    check("edge_rdata", 64'(rd), 64'hDEADBEEF);

    // back-to-back with cmd_valid held high
    @(negedge PCLK);
    #1 base = rsp_seen;
    send(1'b1, 8'h01, 32'h1111_2222, 0, 1'b1); n1 = cyc;
    send(1'b0, 8'h01, 32'h0, 0, 1'b1);         n2 = cyc;
    send(1'b1, 8'hFF, 32'h3333_4444, 0, 1'b1); n3 = cyc;
    send(1'b0, 8'hFF, 32'h0, 0, 1'b0);         n4 = cyc;
    repeat (6) @(negedge PCLK);
    #1;
    check("b2b_space1", 64'(n2 - n1), 64'd3);
    check("b2b_space2", 64'(n3 - n2), 64'd3);
    check("b2b_space3", 64'(n4 - n3), 64'd3);
    check("b2b_pulses", 64'(rsp_seen - base), 64'd4);
    check("b2b_rd01", 64'(rd_log[(base + 1) % 1024]), 64'h1111_2222);
    check("b2b_rdFF", 64'(rd_log[(base + 3) % 1024]), 64'h3333_4444);

    // TIMEOUT=0 instance: 100 wait states then a normal read completion
    @(negedge PCLK);
    bus0.cmd_valid = 1; bus0.cmd_write = 0; bus0.cmd_addr = 8'h20;
    n0 = -1;
    for (int i = 0; i < 10 && n0 < 0; i++) begin
      @(negedge PCLK);
      if (bus0.PSEL) n0 = cyc;
    end
    bus0.cmd_valid = 0;
    acc0 = 0; pulses0 = 0; at0 = -1; err0 = 1'b1; rd0 = '0;
    for (int i = 0; i < 200; i++) begin
      if (bus0.PSEL && bus0.PENABLE) begin
        bus0.PREADY = (acc0 >= 100);
        bus0.PRDATA = (acc0 >= 100) ? 32'h1234_5678 : DW'($urandom);
        acc0++;
      end else begin
        bus0.PREADY = 0;
      end
      @(negedge PCLK);
      if (bus0.rsp_valid) begin
        pulses0++;
        if (at0 < 0) begin
          at0 = cyc; err0 = bus0.rsp_err; rd0 = bus0.rsp_rdata;
        end
      end
    end
    check("t0_latency", 64'(at0 - n0), 64'd102);
    check("t0_err", 64'(err0), 64'd0);
    check("t0_rdata", 64'(rd0), 64'h1234_5678);
    check("t0_pulses", 64'(pulses0), 64'd1);

    // reset mid-ACCESS drops the in-flight write with no response
    send(1'b1, 8'h30, 32'hCAFE_F00D, 10, 1'b0);
    repeat (2) @(negedge PCLK);
    #2 PRESETn = 1'b0;
    chk_en = 0;
    #1;
    check("arst_psel", 64'(bus.PSEL), 64'd0);
    check("arst_penable", 64'(bus.PENABLE), 64'd0);
    check("arst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("arst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    base = rsp_seen;
    repeat (2) @(negedge PCLK);
    #2 PRESETn = 1'b1;
    check("rel_cmd_ready_early", 64'(bus.cmd_ready), 64'd0);
    chk_en = 1;
    @(negedge PCLK);
    check("rel_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    repeat (5) @(negedge PCLK);
    #1 check("rel_no_rsp", 64'(rsp_seen - base), 64'd0);
    @(negedge PCLK);
    send(1'b0, 8'h30, 32'h0, 0, 1'b0);
    wait_rsp(at, err, rd);
    check("dropped_write", 64'(rd), 64'(init_val(8'h30)));

    // randomized traffic; the per-cycle compare carries the checking
    for (int it = 0; it < 200; it++) begin
      int gap, r, w;
      gap = $urandom_range(0, 3);
      repeat (gap) begin
        bus.cmd_valid = 0;
        bus.cmd_write = 1'($urandom); bus.cmd_addr = AW'($urandom); bus.cmd_wdata = DW'($urandom);
        @(negedge PCLK);
      end
      r = $urandom_range(0, 9);
      if (r < 6)      w = $urandom_range(0, 3);
      else if (r < 8) w = $urandom_range(4, 8);
      else            w = $urandom_range(14, 18);
      send(1'($urandom), AW'($urandom_range(0, 15)), DW'($urandom), w, 1'($urandom_range(0, 1)));
    end
    bus.cmd_valid = 0;
    repeat (30) @(negedge PCLK);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
